zero_cross_period: RTL and testbench

//  Downstream end of the zero-crossing flag interface. Consumes the 1-cycle

---
 rtl/zero_cross_period_if.sv | 30 +++
 rtl/zero_cross_period.sv | 133 +++++++++++++
 tb/tb_zero_cross_period.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/zero_cross_period_if.sv
// Crossing flag / period result bundle between detector side and period counter.
// Parameterised on the counter width so both ends agree on the period bus.
interface zero_cross_period_if #(
   parameter int CNT_W = 16
);
   logic             enable;
   logic             flag;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             locked;
   logic             timeout;

   modport master (
      output enable,
      output flag,
      input  period,
      input  period_valid,
      input  locked,
      input  timeout
   );

   modport slave (
      input  enable,
      input  flag,
      output period,
      output period_valid,
      output locked,
      output timeout
   );
endinterface

// File: rtl/zero_cross_period.sv
// Counts enabled samples between accepted zero crossings, with glitch rejection
// and saturation timeout. Define ZERO_CROSS_PERIOD_AVG_EN to average 2^LOG2_AVG periods.
module zero_cross_period #(
   parameter int CNT_W      = 16,
   parameter int MIN_PERIOD = 4,
   parameter int LOG2_AVG   = 2
) (
   input  logic                clk,
   input  logic                reset,
   zero_cross_period_if.slave  bus
);

   typedef enum logic {IDLE, MEASURE} state_t;

   localparam logic [CNT_W-1:0] CMAX = '1;
   localparam logic [CNT_W:0]   MINP = (CNT_W+1)'(MIN_PERIOD);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [CNT_W-1:0] period, period_n;
   logic             pvalid, pvalid_n;
   logic             locked, locked_n;
   logic             tout, tout_n;

   logic [CNT_W:0]   n;
   logic [CNT_W-1:0] nsat;
   logic             accept;
   logic             sat;

`ifdef ZERO_CROSS_PERIOD_AVG_EN
   logic [CNT_W+LOG2_AVG-1:0] acc, acc_n, acc_sum;
   logic [LOG2_AVG-1:0]       accn, accn_n;
`endif

   assign bus.period       = period;
   assign bus.period_valid = pvalid;
   assign bus.locked       = locked;
   assign bus.timeout      = tout;

   // Candidate period counts a sample arriving with the closing flag.
   always_comb begin
      n      = {1'b0, cnt} + (CNT_W+1)'(bus.enable);
      nsat   = n[CNT_W] ? CMAX : n[CNT_W-1:0];
      accept = (state == MEASURE) && bus.flag && (n >= MINP);
      sat    = (state == MEASURE) && bus.enable && (cnt == CMAX) && !accept;
   end

   // Next-state, counter and registered result logic.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      period_n = period;
      pvalid_n = 1'b0;
      locked_n = locked;
      tout_n   = 1'b0;
`ifdef ZERO_CROSS_PERIOD_AVG_EN
      acc_n    = acc;
      accn_n   = accn;
      acc_sum  = acc + {{LOG2_AVG{1'b0}}, nsat};
`endif
      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (bus.flag) state_n = MEASURE;
         end
         MEASURE: begin
            unique case (1'b1)
               accept: begin
                  cnt_n = '0;
`ifdef ZERO_CROSS_PERIOD_AVG_EN
                  if (accn == '1) begin
                     period_n = acc_sum[CNT_W+LOG2_AVG-1:LOG2_AVG];
                     pvalid_n = 1'b1;
                     locked_n = 1'b1;
                     acc_n    = '0;
                     accn_n   = '0;
                  end else begin
                     acc_n  = acc_sum;
                     accn_n = accn + 1'b1;
                  end
`else
                  period_n = nsat;
                  pvalid_n = 1'b1;
                  locked_n = 1'b1;
`endif
               end
               sat: begin
                  cnt_n    = '0;
                  tout_n   = 1'b1;
                  locked_n = 1'b0;
                  state_n  = IDLE;
`ifdef ZERO_CROSS_PERIOD_AVG_EN
                  acc_n    = '0;
                  accn_n   = '0;
`endif
               end
               default: begin
                  if (bus.enable) cnt_n = cnt + 1'b1;
               end
            endcase
         end
         default: state_n = IDLE;
      endcase
   end

   // State and output registers; reset overrides everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         period <= '0;
         pvalid <= 1'b0;
         locked <= 1'b0;
         tout   <= 1'b0;
`ifdef ZERO_CROSS_PERIOD_AVG_EN
         acc    <= '0;
         accn   <= '0;
`endif
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         period <= period_n;
         pvalid <= pvalid_n;
         locked <= locked_n;
         tout   <= tout_n;
`ifdef ZERO_CROSS_PERIOD_AVG_EN
         acc    <= acc_n;
         accn   <= accn_n;
`endif
      end
   end

endmodule

// File: tb/tb_zero_cross_period.sv
// Directed bench for zero_cross_period with an 8-bit counter.
// Drives inputs 1 time unit after each rising edge and checks registered results there.
module tb_zero_cross_period;

   localparam int W = 8;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   zero_cross_period_if #(.CNT_W(W)) bus ();

   zero_cross_period #(.CNT_W(W), .MIN_PERIOD(4), .LOG2_AVG(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic gap(input int k);
      bus.flag = 1'b0;
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic pulse;
      bus.flag = 1'b1;
      tick();
      bus.flag = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset;
      reset      = 1'b1;
      bus.flag   = 1'b0;
      bus.enable = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      bus.enable = 1'b0;
      bus.flag   = 1'b0;
      tick();
      tick();
      chk("rst_period", 32'(bus.period), 0);
      chk("rst_valid", 32'(bus.period_valid), 0);
      chk("rst_locked", 32'(bus.locked), 0);
      chk("rst_timeout", 32'(bus.timeout), 0);
      reset = 1'b0;

`ifdef ZERO_CROSS_PERIOD_AVG_EN
      do_reset();
      pulse();
      gap(99);
      pulse();
      chk("avg_nv1", 32'(bus.period_valid), 0);
      gap(101);
      pulse();
      chk("avg_nv2", 32'(bus.period_valid), 0);
      gap(97);
      pulse();
      chk("avg_nv3", 32'(bus.period_valid), 0);
      chk("avg_unlocked", 32'(bus.locked), 0);
      gap(100);
      pulse();
      chk("avg_valid", 32'(bus.period_valid), 1);
      chk("avg_period", 32'(bus.period), 100);
      chk("avg_locked", 32'(bus.locked), 1);
      tick();
      chk("avg_valid_drop", 32'(bus.period_valid), 0);
`else
      // continuous enable, flags 100 apart
      do_reset();
      pulse();
      chk("t1_first_nv", 32'(bus.period_valid), 0);
      chk("t1_first_unlk", 32'(bus.locked), 0);
      gap(99);
      pulse();
      chk("t1_valid", 32'(bus.period_valid), 1);
      chk("t1_period", 32'(bus.period), 100);
      chk("t1_locked", 32'(bus.locked), 1);
      tick();
      chk("t1_valid_drop", 32'(bus.period_valid), 0);
      gap(98);
      pulse();
      chk("t1_valid3", 32'(bus.period_valid), 1);
      chk("t1_period3", 32'(bus.period), 100);

      // enable every 4th cycle, flags 200 apart
      do_reset();
      for (int c = 0; c <= 200; c++) begin
         bus.enable = (c % 4 == 0);
         bus.flag   = (c == 0) || (c == 200);
         tick();
      end
      bus.flag = 1'b0;
      chk("t2_valid", 32'(bus.period_valid), 1);
      chk("t2_period", 32'(bus.period), 50);

      // glitch rejection
      do_reset();
      pulse();
      gap(99);
      pulse();
      chk("t3_acc", 32'(bus.period), 100);
      gap(1);
      pulse();
      chk("t3_glitch_nv", 32'(bus.period_valid), 0);
      gap(97);
      pulse();
      chk("t3_valid", 32'(bus.period_valid), 1);
      chk("t3_period", 32'(bus.period), 100);

      // timeout
      do_reset();
      pulse();
      gap(99);
      pulse();
      gap(255);
      chk("t4_no_to_yet", 32'(bus.timeout), 0);
      chk("t4_locked_pre", 32'(bus.locked), 1);
      tick();
      chk("t4_timeout", 32'(bus.timeout), 1);
      chk("t4_unlocked", 32'(bus.locked), 0);
      chk("t4_period_kept", 32'(bus.period), 100);
      chk("t4_no_valid", 32'(bus.period_valid), 0);
      tick();
      chk("t4_to_drop", 32'(bus.timeout), 0);
      pulse();
      chk("t4_idle_nv", 32'(bus.period_valid), 0);
      gap(59);
      pulse();
      chk("t4_valid60", 32'(bus.period_valid), 1);
      chk("t4_period60", 32'(bus.period), 60);

      // reset mid-period with flag
      do_reset();
      pulse();
      gap(99);
      pulse();
      gap(30);
      reset    = 1'b1;
      bus.flag = 1'b1;
      tick();
      reset    = 1'b0;
      bus.flag = 1'b0;
      chk("t5_period", 32'(bus.period), 0);
      chk("t5_locked", 32'(bus.locked), 0);
      chk("t5_valid", 32'(bus.period_valid), 0);
      chk("t5_timeout", 32'(bus.timeout), 0);
      pulse();
      chk("t5_first_nv", 32'(bus.period_valid), 0);
      gap(10);
      pulse();
      chk("t5_period11", 32'(bus.period), 11);
      chk("t5_valid11", 32'(bus.period_valid), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
